lfsr_checker_8bit: RTL

LFSR_CHECKER_8BIT -- requirements
Module: lfsr_checker_8bit

---
 rtl/lfsr_checker_8bit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lfsr_checker_8bit.sv
// LFSR sequence checker: hunts for a nonzero seed, verifies LOCK_COUNT predicted words, then tracks errors while locked.
// Optional LFSR_CHK_STATS_EN adds a word_count output counting samples consumed while locked.
module lfsr_checker_8bit #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_valid,
    input  logic [7:0]  data_in,
    input  logic        clr,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
`ifdef LFSR_CHK_STATS_EN
    output logic [31:0] word_count,
`endif
    output logic [7:0]  expected
);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_COUNT - 1);

    state_t      state, state_next;
    logic [3:0]  match_cnt, match_next;
    logic [3:0]  miss_cnt, miss_next;
    logic [7:0]  expected_next;
    logic        locked_next;
    logic        err_pulse_next;
    logic [15:0] err_count_next;
    logic        mismatch;
    logic        err_hit;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    assign mismatch = (data_in != expected);
    assign err_hit  = data_valid && (state == LOCKED) && mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            expected  <= 8'h00;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= 16'h0000;
        end else begin
            state     <= state_next;
            match_cnt <= match_next;
            miss_cnt  <= miss_next;
            expected  <= expected_next;
            locked    <= locked_next;
            err_pulse <= err_pulse_next;
            err_count <= err_count_next;
        end
    end

    always_comb begin
        state_next    = state;
        match_next    = match_cnt;
        miss_next     = miss_cnt;
        expected_next = expected;
        if (data_valid) begin
            case (state)
                HUNT: begin
                    // An all-zero word would lock the generator, so it is never accepted as a seed.
                    if (data_in != 8'h00) begin
                        expected_next = lfsr_next(data_in);
                        match_next    = 4'd0;
                        state_next    = VERIFY;
                    end
                end
                VERIFY: begin
                    if (!mismatch) begin
                        expected_next = lfsr_next(expected);
                        if (match_cnt == LOCK_LAST) begin
                            match_next = 4'd0;
                            miss_next  = 4'd0;
                            state_next = LOCKED;
                        end else begin
                            match_next = match_cnt + 4'd1;
                        end
                    end else if (data_in != 8'h00) begin
                        expected_next = lfsr_next(data_in);
                        match_next    = 4'd0;
                    end else begin
                        match_next = 4'd0;
                        state_next = HUNT;
                    end
                end
                LOCKED: begin
                    // Free-run the local generator so a corrupted word cannot poison later predictions.
                    expected_next = lfsr_next(expected);
                    if (!mismatch) begin
                        miss_next = 4'd0;
                    end else if (miss_cnt == LOSS_LAST) begin
                        miss_next  = 4'd0;
                        state_next = HUNT;
                    end else begin
                        miss_next = miss_cnt + 4'd1;
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    always_comb begin
        locked_next    = (state_next == LOCKED);
        err_pulse_next = err_hit;
        err_count_next = err_count;
        if (clr) begin
            err_count_next = 16'h0000;
        end else if (err_hit && (err_count != 16'hFFFF)) begin
            err_count_next = err_count + 16'd1;
        end
    end

`ifdef LFSR_CHK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= 32'd0;
        end else if (clr) begin
            word_count <= 32'd0;
        end else if (data_valid && (state == LOCKED) && (word_count != 32'hFFFF_FFFF)) begin
            word_count <= word_count + 32'd1;
        end
    end
`endif

endmodule
